// File: rtl/output_display_unit.sv
// Output stage of the NSC-8 datapath: captures a bus value, converts it to decimal
// with a sequential double-dabble, and scans it onto a 4-digit 7-segment display.
module output_display_unit #(
    parameter int REFRESH_DIV    = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] bus_in,
    input  logic       write_enable_output,
    input  logic       signed_mode,
    output logic [7:0] value_out,
    output logic       busy,
    output logic [6:0] seg,
    output logic [3:0] digit_sel
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Digit registers hold symbols: 0..9 are decimal digits, plus these two.
    localparam logic [3:0] SYM_MINUS = 4'hE;
    localparam logic [3:0] SYM_BLANK = 4'hF;

    logic [1:0]  state;
    logic [19:0] shreg;
    logic [2:0]  count;
    logic        neg;
    logic        pend_valid;
    logic [7:0]  pend_value;
    logic        pend_signed;
    logic [3:0]  dig_ones, dig_tens, dig_hund, dig_sign;
    logic [15:0] div;
    logic [1:0]  idx;

    logic [7:0]  src_value;
    logic        src_signed;
    logic        src_neg;
    logic [7:0]  src_mag;
    logic [3:0]  cur_sym;
    logic [6:0]  cur_code;

    // A live strobe takes priority over the buffered write.
    assign src_value  = write_enable_output ? bus_in      : pend_value;
    assign src_signed = write_enable_output ? signed_mode : pend_signed;
    assign src_neg    = src_signed && src_value[7];
    assign src_mag    = src_neg ? (~src_value + 8'd1) : src_value;

    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (r[8 + 4*i +: 4] >= 4'd5)
                r[8 + 4*i +: 4] = r[8 + 4*i +: 4] + 4'd3;
        end
        return {r[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg_code(input logic [3:0] sym);
        case (sym)
            4'd0:      seg_code = 7'h3F;
            4'd1:      seg_code = 7'h06;
            4'd2:      seg_code = 7'h5B;
            4'd3:      seg_code = 7'h4F;
            4'd4:      seg_code = 7'h66;
            4'd5:      seg_code = 7'h6D;
            4'd6:      seg_code = 7'h7D;
            4'd7:      seg_code = 7'h07;
            4'd8:      seg_code = 7'h7F;
            4'd9:      seg_code = 7'h6F;
            SYM_MINUS: seg_code = 7'h40;
            default:   seg_code = 7'h00;
        endcase
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            value_out   <= 8'h00;
            busy        <= 1'b0;
            shreg       <= 20'd0;
            count       <= 3'd0;
            neg         <= 1'b0;
            pend_valid  <= 1'b0;
            pend_value  <= 8'h00;
            pend_signed <= 1'b0;
            dig_ones    <= 4'd0;
            dig_tens    <= SYM_BLANK;
            dig_hund    <= SYM_BLANK;
            dig_sign    <= SYM_BLANK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (write_enable_output || pend_valid) begin
                        value_out  <= src_value;
                        neg        <= src_neg;
                        shreg      <= {12'd0, src_mag};
                        count      <= 3'd0;
                        busy       <= 1'b1;
                        pend_valid <= 1'b0;
                        state      <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg <= dabble_step(shreg);
                    count <= count + 3'd1;
                    if (count == 3'd7)
                        state <= S_DONE;
                end
                S_DONE: begin
                    dig_ones <= shreg[11:8];
                    dig_tens <= (shreg[19:16] == 4'd0 && shreg[15:12] == 4'd0) ? SYM_BLANK : shreg[15:12];
                    dig_hund <= (shreg[19:16] == 4'd0) ? SYM_BLANK : shreg[19:16];
                    dig_sign <= neg ? SYM_MINUS : SYM_BLANK;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase

            // Strobes during a conversion are buffered; the last one wins.
            if (write_enable_output && state != S_IDLE) begin
                pend_valid  <= 1'b1;
                pend_value  <= bus_in;
                pend_signed <= signed_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div <= 16'd0;
            idx <= 2'd0;
        end else if (div == 16'(REFRESH_DIV - 1)) begin
            div <= 16'd0;
            idx <= idx + 2'd1;
        end else begin
            div <= div + 16'd1;
        end
    end

    // NOTE: every output of this block is assigned on all paths, so no latch is inferred.
    always_comb begin
        case (idx)
            2'd0:    cur_sym = dig_ones;
            2'd1:    cur_sym = dig_tens;
            2'd2:    cur_sym = dig_hund;
            default: cur_sym = dig_sign;
        endcase
        cur_code  = seg_code(cur_sym);
        seg       = SEG_ACTIVE_LOW ? ~cur_code : cur_code;
        digit_sel = 4'b0001 << idx;
    end

endmodule

// File: tb/tb_output_display_unit.sv
// Self-checking bench for output_display_unit: directed scenarios plus randomized
// conversions, with a free-running monitor comparing the scanned display to a model.
module tb_output_display_unit;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic       write_enable_output = 1'b0;
    logic       signed_mode = 1'b0;
    logic [7:0] value_out;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] digit_sel;

    int checks = 0;
    int passes = 0;

    // Expected display, packed {sign, hundreds, tens, ones}, 7 bits each.
    localparam logic [27:0] RESET_DISP = {7'h00, 7'h00, 7'h00, 7'h3F};
    logic [27:0] exp_disp = RESET_DISP;
    logic        mon_en = 1'b0;
    int          edges = 0;

    logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       pend_en [1:9];
    logic [7:0] pend_v  [1:9];
    logic       pend_s  [1:9];

    output_display_unit #(
        .REFRESH_DIV   (4),
        .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .bus_in             (bus_in),
        .write_enable_output(write_enable_output),
        .signed_mode        (signed_mode),
        .value_out          (value_out),
        .busy               (busy),
        .seg                (seg),
        .digit_sel          (digit_sel)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release; the scanner index is (edges / 4) mod 4.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edges <= 0;
        else          edges <= edges + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            int e;
            logic [3:0] exp_sel;
            e = (edges / 4) % 4;
            exp_sel = 4'b0001 << e;
            checks++;
            if (digit_sel !== exp_sel)
                $display("FAIL scan_sel: digit_sel=%b expected %b at t=%0t", digit_sel, exp_sel, $time);
            else
                passes++;
            checks++;
            if (seg !== exp_disp[e*7 +: 7])
                $display("FAIL scan_seg: digit %0d seg=%h expected %h at t=%0t", e, seg, exp_disp[e*7 +: 7], $time);
            else
                passes++;
        end
    end

    function automatic logic [27:0] model_disp(input logic [7:0] v, input logic sm);
        bit neg;
        int mag, h, t, o;
        logic [6:0] s_sign, s_hund, s_tens, s_ones;
        neg = sm && v[7];
        mag = neg ? 256 - int'(v) : int'(v);
        h = mag / 100;
        t = (mag / 10) % 10;
        o = mag % 10;
        s_sign = neg ? 7'h40 : 7'h00;
        s_hund = (h != 0) ? seg_tab[h] : 7'h00;
        s_tens = (h != 0 || t != 0) ? seg_tab[t] : 7'h00;
        s_ones = seg_tab[o];
        return {s_sign, s_hund, s_tens, s_ones};
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_pend();
        for (int k = 1; k <= 9; k++) begin
            pend_en[k] = 1'b0;
            pend_v[k]  = 8'h00;
            pend_s[k]  = 1'b0;
        end
    endtask

    // Strobes v at E0, optionally strobes buffered writes at E1..E9 from the pend_* tables,
    // checks busy cycle by cycle, and updates the expected display at each E9.
    task automatic do_convert(input logic [7:0] v, input logic sm);
        logic       have_p;
        logic [7:0] pv;
        logic       psm;
        logic       exp_b;
        have_p = 1'b0;
        pv = 8'h00;
        psm = 1'b0;
        bus_in = v;
        signed_mode = sm;
        write_enable_output = 1'b1;
        tick();
        write_enable_output = 1'b0;
        bus_in = 8'($urandom);
        signed_mode = 1'($urandom);
        checks++;
        if (busy !== 1'b1) $display("FAIL conv_start_busy: busy=%b expected 1", busy);
        else passes++;
        checks++;
        if (value_out !== v) $display("FAIL conv_value_out: value_out=%h expected %h", value_out, v);
        else passes++;
        for (int k = 1; k <= 9; k++) begin
            if (pend_en[k]) begin
                bus_in = pend_v[k];
                signed_mode = pend_s[k];
                write_enable_output = 1'b1;
                have_p = 1'b1;
                pv = pend_v[k];
                psm = pend_s[k];
            end
            tick();
            write_enable_output = 1'b0;
            exp_b = (k <= 8);
            checks++;
            if (busy !== exp_b) $display("FAIL conv_busy: E%0d busy=%b expected %b", k, busy, exp_b);
            else passes++;
        end
        exp_disp = model_disp(v, sm);
        if (have_p) begin
            tick();
            checks++;
            if (busy !== 1'b1 || value_out !== pv)
                $display("FAIL pend_start: busy=%b value_out=%h expected 1 %h", busy, value_out, pv);
            else passes++;
            for (int k = 1; k <= 9; k++) begin
                tick();
                exp_b = (k <= 8);
                checks++;
                if (busy !== exp_b) $display("FAIL pend_busy: E%0d busy=%b expected %b", k + 10, busy, exp_b);
                else passes++;
            end
            exp_disp = model_disp(pv, psm);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        exp_disp = RESET_DISP;
        mon_en = 1'b1;
        checks++;
        if (value_out !== 8'h00 || busy !== 1'b0)
            $display("FAIL reset_state: value_out=%h busy=%b expected 00 0", value_out, busy);
        else passes++;
        reset_n = 1'b1;
        repeat (16) tick();
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy=%b expected 0", busy);
        else passes++;
    endtask

    task automatic test_unsigned_max();
        clear_pend();
        do_convert(8'hFF, 1'b0);
        repeat (16) tick();
        checks++;
        if (value_out !== 8'hFF) $display("FAIL unsigned_max_value: value_out=%h expected ff", value_out);
        else passes++;
    endtask

    task automatic test_signed_extremes();
        clear_pend();
        do_convert(8'h80, 1'b1);
        repeat (16) tick();
        do_convert(8'hFF, 1'b1);
        repeat (16) tick();
    endtask

    task automatic test_back_to_back();
        clear_pend();
        pend_en[2] = 1'b1; pend_v[2] = 8'h22; pend_s[2] = 1'b0;
        pend_en[5] = 1'b1; pend_v[5] = 8'h07; pend_s[5] = 1'b0;
        do_convert(8'h0C, 1'b0);
        repeat (16) tick();
        clear_pend();
    endtask

    task automatic test_scanner();
        logic [3:0] prev;
        int last_change;
        int n_changes;
        prev = digit_sel;
        last_change = -1;
        n_changes = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (digit_sel !== prev) begin
                if (last_change >= 0) begin
                    checks++;
                    if (c - last_change != 4)
                        $display("FAIL scan_interval: %0d clocks expected 4", c - last_change);
                    else passes++;
                end
                last_change = c;
                n_changes++;
                prev = digit_sel;
            end
        end
        checks++;
        if (n_changes < 5) $display("FAIL scan_changes: %0d changes expected at least 5", n_changes);
        else passes++;
    endtask

    task automatic test_reset_mid();
        clear_pend();
        bus_in = 8'hC8;
        signed_mode = 1'b0;
        write_enable_output = 1'b1;
        tick();
        bus_in = 8'h33;
        tick();
        write_enable_output = 1'b0;
        repeat (3) tick();
        reset_n = 1'b0;
        exp_disp = RESET_DISP;
        #1;
        checks++;
        if (busy !== 1'b0 || value_out !== 8'h00)
            $display("FAIL reset_mid_async: busy=%b value_out=%h expected 0 00", busy, value_out);
        else passes++;
        tick();
        tick();
        reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || value_out !== 8'h00)
                $display("FAIL reset_mid_stale: cycle %0d busy=%b value_out=%h expected 0 00", c, busy, value_out);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic [7:0] v;
        logic       sm;
        for (int n = 0; n < 25; n++) begin
            clear_pend();
            v = 8'($urandom);
            sm = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                int k;
                k = $urandom_range(1, 9);
                pend_en[k] = 1'b1;
                pend_v[k] = 8'($urandom);
                pend_s[k] = 1'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    k = $urandom_range(1, 9);
                    pend_en[k] = 1'b1;
                    pend_v[k] = 8'($urandom);
                    pend_s[k] = 1'($urandom);
                end
            end
            do_convert(v, sm);
            repeat ($urandom_range(0, 4)) tick();
        end
        repeat (16) tick();
        clear_pend();
    endtask

    initial begin
        clear_pend();
        test_reset();
        test_unsigned_max();
        test_signed_extremes();
        test_back_to_back();
        test_scanner();
        test_reset_mid();
        test_random();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/output_display_unit.md
Name: output_display_unit

Overview:
Output stage of the NSC-8 datapath, directly downstream of the controller. When write_enable_output is asserted, it captures the 8-bit bus value and converts it to decimal. The conversion is a sequential double-dabble (shift-add-3). The result drives a 4-digit, time-multiplexed 7-segment display: sign, hundreds, tens and ones. Writes that arrive mid-conversion are buffered one deep.

Parameters:
REFRESH_DIV, 4, clocks each digit stays selected before the scanner advances; legal range 1..65535.
SEG_ACTIVE_LOW, 0, 1 inverts seg[6:0] at the output pins. All behaviour below is stated for 0.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
bus_in  input  8  datapath bus value.
write_enable_output  input  1  controller strobe; sampled on the rising clk edge.
signed_mode  input  1  1 = interpret the value as two's complement; sampled together with bus_in.
value_out  output  8  last accepted raw bus value.
busy  output  1  conversion in progress.
seg  output  7  segment pattern {g,f,e,d,c,b,a} for the selected digit.
digit_sel  output  4  one-hot digit enable; bit0 = ones, bit1 = tens, bit2 = hundreds, bit3 = sign.

Behaviour:
- Reset (async, reset_n=0):
  - State machine goes to IDLE.
  - value_out=0, busy=0, pending buffer cleared.
  - Digit registers: ones='0', tens/hundreds/sign=blank.
  - Scanner index=0, digit_sel=4'b0001, divider=0.
  - Reset mid-conversion aborts it; no partial result is ever displayed.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: start a conversion at edge E0 if write_enable_output=1 or pending_valid=1.
  - A live strobe beats pending and clears pending.
  - At E0: value_out <= source value.
  - Magnitude: if signed_mode && bit7, magnitude = -value (8-bit two's complement, 0x80 -> 128); otherwise the raw value.
  - Store neg flag; load the shift register {bcd[11:0]=0, mag[7:0]}; shift count=0; busy<=1; go to SHIFT.
- SHIFT: edges E1..E8 each do one double-dabble step.
  - Add 3 to every BCD nibble that is >= 5, then shift left by 1.
  - At E8 (count=7), go to DONE.
- DONE (edge E9): load the display digit registers, then busy<=0 and go to IDLE.
  - Leading zeros in hundreds and tens are blanked; tens is shown whenever hundreds is nonzero.
  - Ones digit is always shown.
  - Sign digit shows '-' if neg, otherwise blank.
- Latency: the strobe is sampled at E0; busy is high from E0 through E8 (9 cycles); the display updates at E9.
  - If pending exists, the next E0 is E10 (one IDLE cycle).
- Strobe while busy (SHIFT or DONE): capture bus_in and signed_mode into the pending buffer and set pending_valid.
  - A later strobe overwrites pending (last write wins). The in-flight conversion is not disturbed.
- Display registers change only at DONE; digits are never torn mid-scan.
- Segment codes:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - '-'=40, blank=00.
- Scanner: runs freely, independent of the state machine.
  - The divider counts 0..REFRESH_DIV-1; on wrap, the index advances 0->1->2->3->0.
  - digit_sel = one-hot(index); seg = the code of the indexed digit register, combinational from registers.

Test Plan:
- Reset: hold reset_n=0 for 2 clocks, release -> value_out=00, busy=0, digit_sel=0001, seg=3F on index 0; seg=00 on indices 1..3 over 16 clocks.
- Unsigned max: bus_in=FF, signed_mode=0, strobe 1 cycle -> busy high 9 cycles, then digits '2','5','5', sign blank (seg 5B, 6D, 6D, 00); value_out=FF.
- Signed extremes: strobe 80 with signed_mode=1 -> '-','1','2','8' (40, 06, 5B, 7F). Then FF signed -> sign '-', hundreds blank, tens blank, ones '1' (40, 00, 00, 06).
- Back-to-back writes: strobe 0C, then during busy strobe 22 and then 07 -> display shows 12 at E9. A second conversion starts at E10 and shows 7, never 34 (22 was overwritten).
- Scanner timing with REFRESH_DIV=4: digit_sel sequence 0001, 0010, 0100, 1000, 0001 changes exactly every 4 clocks; it is unaffected by a concurrent conversion.
- Reset mid-conversion: strobe C8, assert reset_n=0 at E4 -> busy=0 immediately, pending cleared, display returns to reset values. After release, no stale result appears.
